// File: rtl/core_array_ctrl.sv
// rtl/core_array_ctrl.sv - core-array control: misc opcode decode, enable mask, global regs, output serializer
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   opcode, execute   opcode and its valid strobe
//   accu_flat         core accumulators, core i at [i*2*BIT_WIDTH +: 2*BIT_WIDTH]
//   core_execute      per-core execute strobe (execute gated by the enable mask)
//   global_regs_flat  global registers, reg g at [g*BIT_WIDTH +: BIT_WIDTH]
//   output_bit        serialised accumulator bit, LSB first
//   valid_bit         output_bit valid this cycle
//   out_busy          serializer cannot accept a new output command
//   out_overrun       sticky: an output command was dropped while busy
module core_array_ctrl #(
    parameter int NR_CORES   = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int NR_GLOBALS = 9,
    parameter int OUT_BITS   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [15:0]                      opcode,
    input  logic                             execute,
    input  logic [NR_CORES*2*BIT_WIDTH-1:0]  accu_flat,
    output logic [NR_CORES-1:0]              core_execute,
    output logic [NR_GLOBALS*BIT_WIDTH-1:0]  global_regs_flat,
    output logic                             output_bit,
    output logic                             valid_bit,
    output logic                             out_busy,
    output logic                             out_overrun
);

    localparam int AW = 2 * BIT_WIDTH;
    localparam int CW = $clog2(OUT_BITS + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t               state;
    logic [NR_CORES-1:0]  mask;
    logic [NR_CORES-1:0]  mask_nx;
    logic [BIT_WIDTH-1:0] glob [NR_GLOBALS];
    logic [OUT_BITS-1:0]  shreg;
    logic [CW-1:0]        remain;      // bits still to emit after the one presented

    logic                 misc;
    logic [4:0]           idx;
    int                   idx_i;
    logic                 core_ok;
    logic                 glob_ok;
    logic [AW-1:0]        src;
    logic                 src_ok;
    logic [OUT_BITS-1:0]  accu_sel;
    logic                 store_en;
    logic                 out_cmd;
    logic                 accept;

    assign misc    = execute && (opcode[15:14] == 2'b11);
    assign idx     = opcode[13:9];
    assign idx_i   = {27'd0, idx};
    assign core_ok = idx_i < NR_CORES;
    assign glob_ok = idx_i < NR_GLOBALS;

    assign core_execute = {NR_CORES{execute}} & mask;

    // Descending scan so the lowest enabled core is the last one to win.
    always_comb begin
        src      = '0;
        src_ok   = 1'b0;
        accu_sel = '0;
        for (int i = NR_CORES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                src    = accu_flat[i*AW +: AW];
                src_ok = 1'b1;
            end
            if (idx_i == i) begin
                accu_sel = accu_flat[i*AW +: OUT_BITS];
            end
        end
    end

    always_comb begin
        mask_nx = mask;
        case (opcode[6:5])
            2'b01: begin
                if (core_ok) begin
                    for (int i = 0; i < NR_CORES; i++) mask_nx[i] = (idx_i == i);
                end
            end
            2'b10: mask_nx = '1;
            2'b11: begin
                for (int i = 0; i < NR_CORES; i++) mask_nx[i] = mask[i] ^ (idx_i == i);
            end
            default: mask_nx = mask;
        endcase
    end

    assign store_en = misc && opcode[7] && src_ok && glob_ok;
    assign out_cmd  = misc && opcode[4] && core_ok;
    assign accept   = out_cmd && !out_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '1;
            for (int g = 0; g < NR_GLOBALS; g++) glob[g] <= '0;
        end else begin
            if (misc) mask <= mask_nx;
            if (store_en) begin
                for (int g = 0; g < NR_GLOBALS; g++) begin
                    if (idx_i == g) glob[g] <= src[BIT_WIDTH-1:0];
                end
            end
        end
    end

    // Serializer. A command is accepted while the final bit is presented,
    // so consecutive streams can run with no valid gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shreg       <= '0;
            remain      <= '0;
            output_bit  <= 1'b0;
            valid_bit   <= 1'b0;
            out_busy    <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            if (out_cmd && out_busy) out_overrun <= 1'b1;
            if (accept) begin
                state      <= S_SHIFT;
                output_bit <= accu_sel[0];
                shreg      <= accu_sel >> 1;
                remain     <= CW'(OUT_BITS - 1);
                valid_bit  <= 1'b1;
                out_busy   <= (OUT_BITS > 1);
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (remain != '0) begin
                            output_bit <= shreg[0];
                            shreg      <= shreg >> 1;
                            remain     <= remain - CW'(1);
                            out_busy   <= (remain > CW'(1));
                        end else begin
                            state      <= S_IDLE;
                            valid_bit  <= 1'b0;
                            output_bit <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NR_GLOBALS; g++) begin : g_glob
        assign global_regs_flat[g*BIT_WIDTH +: BIT_WIDTH] = glob[g];
    end

    logic unused_bits;
    assign unused_bits = ^{opcode[8], opcode[3:0], src[AW-1:BIT_WIDTH]};

endmodule

// File: tb/tb_core_array_ctrl.sv
// tb/tb_core_array_ctrl.sv - scoreboard testbench for core_array_ctrl
module tb_core_array_ctrl;

    localparam int NC = 4;
    localparam int BW = 8;
    localparam int NG = 9;
    localparam int OB = 4;

    logic            clk;
    logic            rst_n;
    logic [15:0]     opcode;
    logic            execute;
    logic [NC*2*BW-1:0] accu_flat;
    logic [NC-1:0]   core_execute;
    logic [NG*BW-1:0] global_regs_flat;
    logic            output_bit;
    logic            valid_bit;
    logic            out_busy;
    logic            out_overrun;

    logic [15:0]     accu [NC];
    logic [BW-1:0]   exp_glob [NG];

    typedef struct packed {
        logic b;
        logic busy;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic prev_valid;

    int n_cmp;
    int n_err;

    core_array_ctrl #(
        .NR_CORES  (NC),
        .BIT_WIDTH (BW),
        .NR_GLOBALS(NG),
        .OUT_BITS  (OB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .execute         (execute),
        .accu_flat       (accu_flat),
        .core_execute    (core_execute),
        .global_regs_flat(global_regs_flat),
        .output_bit      (output_bit),
        .valid_bit       (valid_bit),
        .out_busy        (out_busy),
        .out_overrun     (out_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NC; i++) accu_flat[i*2*BW +: 2*BW] = accu[i];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each valid cycle pops one expected bit; a drop in valid while bits are
    // still queued means the stream broke.
    always @(negedge clk) begin
        if (valid_bit) begin
            if (q.size() == 0) begin
                check_val("unexpected_valid", 32'(valid_bit), 32'd0);
            end else begin
                e = q.pop_front();
                check_val("output_bit", 32'(output_bit), 32'(e.b));
                check_val("out_busy", 32'(out_busy), 32'(e.busy));
            end
        end else if (prev_valid && q.size() != 0) begin
            check_val("valid_gap", 32'(valid_bit), 32'd1);
        end
        prev_valid = valid_bit;
    end

    task automatic push_stream(input logic [15:0] a);
        for (int k = 0; k < OB; k++) q.push_back('{b: a[k], busy: (k < OB - 1)});
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic exec_op(input logic [15:0] op);
        opcode  = op;
        execute = 1'b1;
        @(negedge clk);
        execute = 1'b0;
        opcode  = 16'h0000;
    endtask

    task automatic probe(input string tag, input logic [NC-1:0] exp);
        opcode  = 16'h0000;
        execute = 1'b1;
        #1;
        check_val(tag, 32'(core_execute), 32'(exp));
        execute = 1'b0;
    endtask

    task automatic check_globals();
        for (int g = 0; g < NG; g++)
            check_val($sformatf("glob%0d", g), 32'(global_regs_flat[g*BW +: BW]), 32'(exp_glob[g]));
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
        check_val("drain_timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        prev_valid = 1'b0;
        rst_n      = 1'b0;
        execute    = 1'b0;
        opcode     = 16'h0000;
        for (int i = 0; i < NC; i++) accu[i] = 16'h0000;
        for (int g = 0; g < NG; g++) exp_glob[g] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(valid_bit), 32'd0);
        check_val("rst_busy", 32'(out_busy), 32'd0);
        check_val("rst_overrun", 32'(out_overrun), 32'd0);
        probe("rst_mask", 4'b1111);
        check_globals();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Enable control
        exec_op(16'hC220);
        probe("en_onehot", 4'b0010);
        exec_op(16'hC660);
        probe("en_toggle", 4'b1010);
        exec_op(16'hC040);
        probe("en_all", 4'b1111);
        exec_op(16'hCA20);                  // one-hot idx 5: out of range
        probe("en_onehot_oor", 4'b1111);

        // Global store
        exec_op(16'hC060);
        exec_op(16'hC460);
        probe("mask_1010", 4'b1010);
        accu[1] = 16'h00A5;
        accu[3] = 16'h0011;
        exec_op(16'hC480);
        exp_glob[2] = 8'hA5;
        check_globals();
        exec_op(16'hC260);
        exec_op(16'hC660);
        probe("mask_empty", 4'b0000);
        exec_op(16'hC680);                  // empty mask: no write
        exec_op(16'hC040);
        accu[0] = 16'h1234;
        exec_op(16'hE880);                  // idx 20: no write
        check_globals();
        exec_op(16'hD080);                  // idx 8: last global
        exp_glob[8] = 8'h34;
        check_globals();

        // Serialise
        accu[2] = 16'h000B;
        push_stream(accu[2]);
        exec_op(16'hC410);
        drain();
        check_val("ser_idle_valid", 32'(valid_bit), 32'd0);
        check_val("ser_idle_busy", 32'(out_busy), 32'd0);
        exec_op(16'hC810);                  // output idx 4: ignored
        @(negedge clk);
        check_val("oor_out_valid", 32'(valid_bit), 32'd0);
        check_val("oor_out_overrun", 32'(out_overrun), 32'd0);

        // Handshake: drop while busy, accept during final bit
        accu[1] = 16'h0006;
        push_stream(accu[1]);
        exec_op(16'hC210);
        exec_op(16'hC210);
        check_val("overrun_set", 32'(out_overrun), 32'd1);
        @(negedge clk);
        @(negedge clk);
        accu[3] = 16'h000D;
        push_stream(accu[3]);
        exec_op(16'hC610);
        drain();
        check_val("overrun_sticky", 32'(out_overrun), 32'd1);

        // Combined store + one-hot + output
        exec_op(16'hC060);
        probe("mask_1110", 4'b1110);
        accu[1] = 16'h003C;
        accu[2] = 16'h0005;
        push_stream(accu[2]);
        exec_op(16'hC4B0);
        exp_glob[2] = 8'h3C;
        accu[2] = 16'h000F;                 // must not affect the stream
        probe("comb_mask", 4'b0100);
        drain();
        check_globals();

        // Reset mid-stream
        push_stream(accu[2]);
        exec_op(16'hC410);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_val("midrst_valid", 32'(valid_bit), 32'd0);
        check_val("midrst_busy", 32'(out_busy), 32'd0);
        check_val("midrst_overrun", 32'(out_overrun), 32'd0);
        check_val("midrst_bit", 32'(output_bit), 32'd0);
        probe("midrst_mask", 4'b1111);
        for (int g = 0; g < NG; g++) exp_glob[g] = '0;
        check_globals();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_rst_valid", 32'(valid_bit), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
